// File: rtl/config_mem_pkg.sv
// Shared types and helpers for the multi-context configuration memory.
package config_mem_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] cfg_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Context index width; a single-context build still needs one bit.
    function automatic int ctx_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/config_mem_bank.sv
// One stored configuration context: single-word write port, full parallel read.
module config_mem_bank
    import config_mem_pkg::*;
#(
    parameter int WIDTH     = config_mem_pkg::WIDTH,
    parameter int NUM_WORDS = 9,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata [NUM_WORDS]
);

    logic [WIDTH-1:0] mem_r [NUM_WORDS];

    // Word storage, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_r[w] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (we && (waddr == IDX_W'(w))) begin
                    mem_r[w] <= wdata;
                end
            end
        end
    end

    assign rdata = mem_r;

endmodule

// File: rtl/config_mem_ctx.sv
// Multi-context configuration memory: word-serial masked loader, context
// switching with deferral onto an in-flight write, registered active image.
module config_mem_ctx
    import config_mem_pkg::*;
#(
    parameter int WIDTH     = config_mem_pkg::WIDTH,
    parameter int NUM_WORDS = 9,
    parameter int NUM_CTX   = 4,
    parameter int CTX_W     = ctx_w(NUM_CTX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_en,
    input  logic [CTX_W-1:0]     write_ctx,
    input  logic [WIDTH-1:0]     w_data_in [NUM_WORDS],
    input  logic [NUM_WORDS-1:0] w_mask,
    output logic                 write_rdy,
    output logic                 write_ack,
    input  logic                 ctx_switch,
    input  logic [CTX_W-1:0]     ctx_sel,
    output logic                 switch_ack,
    output logic                 cfg_err,
    output logic [CTX_W-1:0]     active_ctx,
    input  logic                 on_off,
    output logic                 on_off_vector_fu,
    output logic [WIDTH-1:0]     r_data_out [NUM_WORDS]
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic [CTX_W-1:0]       tgt_r;
    logic [NUM_WORDS-1:0]   mask_r;
    logic [WIDTH-1:0]       data_r [NUM_WORDS];
    logic                   pend_r;

    logic [WIDTH-1:0]       bank_rd_s    [NUM_CTX][NUM_WORDS];
    logic [WIDTH-1:0]       sel_img_s    [NUM_WORDS];
    logic [WIDTH-1:0]       commit_img_s [NUM_WORDS];

    logic                   accept_s;
    logic                   last_s;
    logic                   sw_bad_s;
    logic                   tgt_bad_s;
    logic                   sw_ok_s;
    logic                   defer_req_s;
    logic                   imm_s;
    logic                   apply_def_s;
    logic                   commit_s;
    logic [CTX_W-1:0]       new_active_s;

    for (genvar c = 0; c < NUM_CTX; c++) begin : g_bank
        config_mem_bank #(
            .WIDTH     (WIDTH),
            .NUM_WORDS (NUM_WORDS),
            .IDX_W     (IDX_W)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    ((state_r == WRITE) && (tgt_r == CTX_W'(c)) && mask_r[idx_r]),
            .waddr (idx_r),
            .wdata (data_r[idx_r]),
            .rdata (bank_rd_s[c])
        );
    end

    assign write_rdy = (state_r == IDLE);

    // Image muxes; the commit image folds in the last word, which is stored on the same edge.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            sel_img_s[w]    = bank_rd_s[0][w];
            commit_img_s[w] = bank_rd_s[0][w];
            for (int c = 1; c < NUM_CTX; c++) begin
                sel_img_s[w]    = (ctx_sel == CTX_W'(c)) ? bank_rd_s[c][w] : sel_img_s[w];
                commit_img_s[w] = (tgt_r == CTX_W'(c))   ? bank_rd_s[c][w] : commit_img_s[w];
            end
        end
        commit_img_s[NUM_WORDS-1] = mask_r[NUM_WORDS-1] ? data_r[NUM_WORDS-1]
                                                        : commit_img_s[NUM_WORDS-1];
    end

    // Switch arbitration: a switch onto the in-flight write target waits for the commit.
    always_comb begin
        accept_s    = write_en && (state_r == IDLE);
        last_s      = (state_r == WRITE) && (idx_r == LAST_IDX);
        sw_bad_s    = ctx_switch && (int'(ctx_sel) >= NUM_CTX);
        tgt_bad_s   = (int'(tgt_r) >= NUM_CTX);
        sw_ok_s     = ctx_switch && !sw_bad_s;
        defer_req_s = sw_ok_s && (state_r == WRITE) && (ctx_sel == tgt_r);
        imm_s       = sw_ok_s && !defer_req_s;
        apply_def_s = last_s && !imm_s && (pend_r || defer_req_s);
        if (imm_s) begin
            new_active_s = ctx_sel;
        end else if (apply_def_s) begin
            new_active_s = tgt_r;
        end else begin
            new_active_s = active_ctx;
        end
        commit_s = last_s && (new_active_s == tgt_r);
    end

    // Load sequencer next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (write_en) begin
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            ACK:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load latches, switch state and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r            <= {IDX_W{1'b0}};
            tgt_r            <= {CTX_W{1'b0}};
            mask_r           <= {NUM_WORDS{1'b0}};
            pend_r           <= 1'b0;
            active_ctx       <= {CTX_W{1'b0}};
            write_ack        <= 1'b0;
            switch_ack       <= 1'b0;
            cfg_err          <= 1'b0;
            on_off_vector_fu <= 1'b0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                data_r[w]     <= {WIDTH{1'b0}};
                r_data_out[w] <= {WIDTH{1'b0}};
            end
        end else begin
            on_off_vector_fu <= on_off;
            write_ack        <= last_s;
            cfg_err          <= sw_bad_s || (last_s && tgt_bad_s);
            switch_ack       <= imm_s || apply_def_s;
            active_ctx       <= new_active_s;

            if (accept_s) begin
                data_r <= w_data_in;
                mask_r <= w_mask;
                tgt_r  <= write_ctx;
                idx_r  <= {IDX_W{1'b0}};
            end else if ((state_r == WRITE) && !last_s) begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end

            if (imm_s || last_s) begin
                pend_r <= 1'b0;
            end else if (defer_req_s) begin
                pend_r <= 1'b1;
            end

            if (commit_s) begin
                r_data_out <= commit_img_s;
            end else if (imm_s) begin
                r_data_out <= sel_img_s;
            end
        end
    end

endmodule

// File: tb/tb_config_mem_ctx.sv
// Directed self-checking bench for config_mem_ctx (default build plus a NUM_CTX=3 build).
module tb_config_mem_ctx;
    import config_mem_pkg::*;

    localparam int NW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            write_en, write_rdy, write_ack;
    logic [1:0]      write_ctx, ctx_sel, active_ctx;
    cfg_word_t       w_data_in [NW];
    cfg_word_t       r_data_out [NW];
    logic [NW-1:0]   w_mask;
    logic            ctx_switch, switch_ack, cfg_err, on_off, on_off_vector_fu;

    logic            b_write_en, b_write_rdy, b_write_ack;
    logic [1:0]      b_write_ctx, b_ctx_sel, b_active_ctx;
    cfg_word_t       b_w_data_in [NW];
    cfg_word_t       b_r_data_out [NW];
    logic [NW-1:0]   b_w_mask;
    logic            b_ctx_switch, b_switch_ack, b_cfg_err, b_on_off, b_on_off_vector_fu;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    cfg_word_t exp_img [NW];

    config_mem_ctx dut (
        .clk(clk), .reset(reset), .write_en(write_en), .write_ctx(write_ctx),
        .w_data_in(w_data_in), .w_mask(w_mask), .write_rdy(write_rdy), .write_ack(write_ack),
        .ctx_switch(ctx_switch), .ctx_sel(ctx_sel), .switch_ack(switch_ack), .cfg_err(cfg_err),
        .active_ctx(active_ctx), .on_off(on_off), .on_off_vector_fu(on_off_vector_fu),
        .r_data_out(r_data_out)
    );

    config_mem_ctx #(.NUM_CTX(3)) dut3 (
        .clk(clk), .reset(reset), .write_en(b_write_en), .write_ctx(b_write_ctx),
        .w_data_in(b_w_data_in), .w_mask(b_w_mask), .write_rdy(b_write_rdy), .write_ack(b_write_ack),
        .ctx_switch(b_ctx_switch), .ctx_sel(b_ctx_sel), .switch_ack(b_switch_ack), .cfg_err(b_cfg_err),
        .active_ctx(b_active_ctx), .on_off(b_on_off), .on_off_vector_fu(b_on_off_vector_fu),
        .r_data_out(b_r_data_out)
    );

    function automatic int img_errs(input cfg_word_t a [NW], input cfg_word_t e [NW]);
        int n = 0;
        for (int i = 0; i < NW; i++) begin
            if (a[i] !== e[i]) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ctx, input logic [NW-1:0] mask);
        write_ctx = ctx;
        w_mask    = mask;
        write_en  = 1'b1;
        tick();
        write_en  = 1'b0;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'hDEAD;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (write_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h0000;
        chk_cnt++; if (write_rdy !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", write_rdy); else pass_cnt++;
        chk_cnt++; if (write_ack !== 1'b0) $display("FAIL reset_wack: got %b expected 0", write_ack); else pass_cnt++;
        chk_cnt++; if (switch_ack !== 1'b0) $display("FAIL reset_sack: got %b expected 0", switch_ack); else pass_cnt++;
        chk_cnt++; if (cfg_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", cfg_err); else pass_cnt++;
        chk_cnt++; if (active_ctx !== 2'd0) $display("FAIL reset_active: got %0d expected 0", active_ctx); else pass_cnt++;
        chk_cnt++; if (on_off_vector_fu !== 1'b0) $display("FAIL reset_fu: got %b expected 0", on_off_vector_fu); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL reset_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        int n;
        int rdy_bad;
        for (int i = 0; i < NW; i++) w_data_in[i] = cfg_word_t'(i * 10);
        load(2'd0, 9'h1FF);
        n = 1;
        rdy_bad = 0;
        while (write_ack !== 1'b1 && n < 20) begin
            if (write_rdy !== 1'b0) rdy_bad++;
            tick();
            n++;
        end
        if (write_rdy !== 1'b0) rdy_bad++;
        for (int i = 0; i < NW; i++) exp_img[i] = cfg_word_t'(i * 10);
        chk_cnt++; if (n != 10) $display("FAIL full_latency: got %0d cycles expected 10", n); else pass_cnt++;
        chk_cnt++; if (write_ack !== 1'b1) $display("FAIL full_ack: got %b expected 1", write_ack); else pass_cnt++;
        chk_cnt++; if (rdy_bad != 0) $display("FAIL full_rdy_low: got %0d high cycles expected 0", rdy_bad); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL full_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
        chk_cnt++; if (write_ack !== 1'b0) $display("FAIL full_ack_pulse: got %b expected 0", write_ack); else pass_cnt++;
        chk_cnt++; if (write_rdy !== 1'b1) $display("FAIL full_rdy_back: got %b expected 1", write_rdy); else pass_cnt++;
    endtask

    task automatic test_masked_switch();
        int n;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'hAAAA;
        load(2'd2, 9'h005);
        wait_ack(n);
        for (int i = 0; i < NW; i++) exp_img[i] = cfg_word_t'(i * 10);
        chk_cnt++; if (write_ack !== 1'b1) $display("FAIL mask_ack: got %b expected 1", write_ack); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL mask_inactive_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
        ctx_switch = 1'b1;
        ctx_sel    = 2'd2;
        tick();
        ctx_switch = 1'b0;
        for (int i = 0; i < NW; i++) exp_img[i] = (i == 0 || i == 2) ? 16'hAAAA : 16'h0000;
        chk_cnt++; if (switch_ack !== 1'b1) $display("FAIL sw_ack: got %b expected 1", switch_ack); else pass_cnt++;
        chk_cnt++; if (active_ctx !== 2'd2) $display("FAIL sw_active: got %0d expected 2", active_ctx); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL sw_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
        chk_cnt++; if (switch_ack !== 1'b0) $display("FAIL sw_ack_pulse: got %b expected 0", switch_ack); else pass_cnt++;
    endtask

    task automatic test_deferred();
        int n;
        int act_bad;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'h1000 + cfg_word_t'(i);
        load(2'd1, 9'h1FF);
        repeat (4) tick();
        ctx_switch = 1'b1;
        ctx_sel    = 2'd1;
        tick();
        ctx_switch = 1'b0;
        chk_cnt++; if (switch_ack !== 1'b0) $display("FAIL def_no_early_ack: got %b expected 0", switch_ack); else pass_cnt++;
        n = 0;
        act_bad = 0;
        while (write_ack !== 1'b1 && n < 20) begin
            if (active_ctx !== 2'd2) act_bad++;
            tick();
            n++;
        end
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h1000 + cfg_word_t'(i);
        chk_cnt++; if (act_bad != 0) $display("FAIL def_hold_active: got %0d bad cycles expected 0", act_bad); else pass_cnt++;
        chk_cnt++; if (n != 4) $display("FAIL def_latency: got %0d expected 4", n); else pass_cnt++;
        chk_cnt++; if (switch_ack !== 1'b1) $display("FAIL def_sack: got %b expected 1", switch_ack); else pass_cnt++;
        chk_cnt++; if (active_ctx !== 2'd1) $display("FAIL def_active: got %0d expected 1", active_ctx); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL def_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
    endtask

    task automatic test_same_cycle();
        int n;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'h5500 + cfg_word_t'(i);
        ctx_switch = 1'b1;
        ctx_sel    = 2'd0;
        load(2'd0, 9'h1FF);
        ctx_switch = 1'b0;
        for (int i = 0; i < NW; i++) exp_img[i] = cfg_word_t'(i * 10);
        chk_cnt++; if (switch_ack !== 1'b1) $display("FAIL same_sack: got %b expected 1", switch_ack); else pass_cnt++;
        chk_cnt++; if (active_ctx !== 2'd0) $display("FAIL same_active: got %0d expected 0", active_ctx); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL same_old_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        wait_ack(n);
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h5500 + cfg_word_t'(i);
        chk_cnt++; if (switch_ack !== 1'b0) $display("FAIL same_no_2nd_sack: got %b expected 0", switch_ack); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL same_commit_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
        ctx_switch = 1'b1;
        ctx_sel    = 2'd0;
        tick();
        ctx_switch = 1'b0;
        chk_cnt++; if (switch_ack !== 1'b1) $display("FAIL self_sack: got %b expected 1", switch_ack); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL self_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
    endtask

    task automatic test_ignored_write();
        int acks;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'h3300 + cfg_word_t'(i);
        load(2'd3, 9'h1FF);
        repeat (2) tick();
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'h9999;
        write_ctx = 2'd0;
        write_en  = 1'b1;
        tick();
        write_en  = 1'b0;
        acks = 0;
        for (int k = 0; k < 14; k++) begin
            if (write_ack === 1'b1) acks++;
            tick();
        end
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h5500 + cfg_word_t'(i);
        chk_cnt++; if (acks != 1) $display("FAIL ign_ack_count: got %0d expected 1", acks); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL ign_ctx0_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        ctx_switch = 1'b1;
        ctx_sel    = 2'd3;
        tick();
        ctx_switch = 1'b0;
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h3300 + cfg_word_t'(i);
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL ign_ctx3_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int n;
        b_ctx_switch = 1'b1;
        b_ctx_sel    = 2'd3;
        tick();
        b_ctx_switch = 1'b0;
        chk_cnt++; if (b_cfg_err !== 1'b1) $display("FAIL oor_sw_err: got %b expected 1", b_cfg_err); else pass_cnt++;
        chk_cnt++; if (b_switch_ack !== 1'b0) $display("FAIL oor_sw_sack: got %b expected 0", b_switch_ack); else pass_cnt++;
        chk_cnt++; if (b_active_ctx !== 2'd0) $display("FAIL oor_sw_active: got %0d expected 0", b_active_ctx); else pass_cnt++;
        tick();
        chk_cnt++; if (b_cfg_err !== 1'b0) $display("FAIL oor_err_pulse: got %b expected 0", b_cfg_err); else pass_cnt++;
        for (int i = 0; i < NW; i++) b_w_data_in[i] = 16'h7700 + cfg_word_t'(i);
        b_write_ctx = 2'd3;
        b_w_mask    = 9'h1FF;
        b_write_en  = 1'b1;
        tick();
        b_write_en  = 1'b0;
        n = 0;
        while (b_write_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h0000;
        chk_cnt++; if (b_write_ack !== 1'b1) $display("FAIL oor_ld_ack: got %b expected 1", b_write_ack); else pass_cnt++;
        chk_cnt++; if (b_cfg_err !== 1'b1) $display("FAIL oor_ld_err: got %b expected 1", b_cfg_err); else pass_cnt++;
        chk_cnt++; if (img_errs(b_r_data_out, exp_img) != 0) $display("FAIL oor_ld_img: got %0d bad words expected 0", img_errs(b_r_data_out, exp_img)); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midload();
        int acks;
        for (int i = 0; i < NW; i++) w_data_in[i] = 16'hBEEF;
        ctx_switch = 1'b1;
        ctx_sel    = 2'd0;
        tick();
        ctx_switch = 1'b0;
        load(2'd0, 9'h1FF);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < NW; i++) exp_img[i] = 16'h0000;
        chk_cnt++; if (write_rdy !== 1'b1) $display("FAIL rst_mid_rdy: got %b expected 1", write_rdy); else pass_cnt++;
        chk_cnt++; if (img_errs(r_data_out, exp_img) != 0) $display("FAIL rst_mid_img: got %0d bad words expected 0", img_errs(r_data_out, exp_img)); else pass_cnt++;
        tick();
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            if (write_ack === 1'b1) acks++;
            tick();
        end
        chk_cnt++; if (acks != 0) $display("FAIL rst_mid_noack: got %0d expected 0", acks); else pass_cnt++;
    endtask

    task automatic test_on_off();
        on_off = 1'b1;
        #1;
        chk_cnt++; if (on_off_vector_fu !== 1'b0) $display("FAIL fu_not_early: got %b expected 0", on_off_vector_fu); else pass_cnt++;
        tick();
        chk_cnt++; if (on_off_vector_fu !== 1'b1) $display("FAIL fu_rise: got %b expected 1", on_off_vector_fu); else pass_cnt++;
        on_off = 1'b0;
        #1;
        chk_cnt++; if (on_off_vector_fu !== 1'b1) $display("FAIL fu_hold: got %b expected 1", on_off_vector_fu); else pass_cnt++;
        tick();
        chk_cnt++; if (on_off_vector_fu !== 1'b0) $display("FAIL fu_fall: got %b expected 0", on_off_vector_fu); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        write_en = 1'b0; write_ctx = 2'd0; w_mask = 9'h000;
        ctx_switch = 1'b0; ctx_sel = 2'd0; on_off = 1'b0;
        b_write_en = 1'b0; b_write_ctx = 2'd0; b_w_mask = 9'h000;
        b_ctx_switch = 1'b0; b_ctx_sel = 2'd0; b_on_off = 1'b0;
        for (int i = 0; i < NW; i++) begin
            w_data_in[i]   = 16'h0000;
            b_w_data_in[i] = 16'h0000;
        end
        test_reset();
        test_full_load();
        test_masked_switch();
        test_deferred();
        test_same_cycle();
        test_ignored_write();
        test_out_of_range();
        test_reset_midload();
        test_on_off();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/config_mem_ctx.md
# config_mem_ctx

Multi-context configuration memory for the vector tile. It holds `NUM_CTX` complete configuration images of `NUM_WORDS` words each and drives the active image to the functional units. A loader writes any context word-serially under a per-word mask while the active image stays stable. A context switch request changes the active image without a reload, and a switch to the context currently being written is deferred until that write commits.

## Interface
- `WIDTH`, 16, bits per configuration word
- `NUM_WORDS`, 9, words per context
- `NUM_CTX`, 4, number of stored contexts (≥2)
- `CTX_W`, `$clog2(NUM_CTX)`, context index width (derived)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `write_en`  in  1  load request; accepted when `write_en && write_rdy`
- `write_ctx`  in  CTX_W  target context of the load
- `w_data_in`  in  NUM_WORDS×WIDTH  load image (unpacked array)
- `w_mask`  in  NUM_WORDS  per-word write enable
- `write_rdy`  out  1  idle, can accept a load
- `write_ack`  out  1  one-cycle commit pulse
- `ctx_switch`  in  1  single-cycle switch request
- `ctx_sel`  in  CTX_W  requested active context
- `switch_ack`  out  1  one-cycle pulse when a switch is applied
- `cfg_err`  out  1  one-cycle pulse on an out-of-range context index
- `active_ctx`  out  CTX_W  current active context
- `on_off`  in  1  FU enable request
- `on_off_vector_fu`  out  1  registered FU enable
- `r_data_out`  out  NUM_WORDS×WIDTH  registered image of the active context

## Operation
- **Reset values.** All storage, `r_data_out`, `active_ctx`, `on_off_vector_fu`, `write_ack`, `switch_ack` and `cfg_err` reset to 0. The FSM resets to IDLE, so `write_rdy` is 1. Reset mid-load aborts the load with no ack, and the storage is zeroed.
- **FSM states.**
  - IDLE → WRITE on accept. `w_data_in`, `w_mask` and `write_ctx` are latched and the word index is set to 0.
  - WRITE: one word is written per cycle. The word at the index is stored if its mask bit is 1, then the index increments. After index `NUM_WORDS-1` the FSM goes to ACK.
  - ACK: `write_ack` is 1 for exactly this cycle, then the FSM returns to IDLE.
- **Handshake.** `write_rdy` equals (state==IDLE). `write_en` is ignored outside IDLE. The requester holds the load data only for the accept cycle.
- **Out-of-range load.** If `write_ctx ≥ NUM_CTX`, the load is still accepted and sequenced, but nothing is stored. `cfg_err` and `write_ack` pulse together in ACK.
- **Commit.** On the edge into ACK, if the target equals `active_ctx` (after any deferred switch), `r_data_out` loads the target's final contents. `r_data_out` never shows a partially written image.
- **Switch.**
  - A valid `ctx_switch` is applied at the sampling edge: `active_ctx` ← `ctx_sel` and `r_data_out` ← the stored image. `switch_ack` follows the next cycle.
  - Exception: if the FSM is in WRITE and `ctx_sel` equals the latched target, the switch becomes pending and is applied on the edge into ACK. In that case `switch_ack` coincides with `write_ack`.
  - A newer `ctx_switch` replaces a pending one. If the newer target is not the write target, it is applied immediately and the pending switch is cleared.
- **Switch to the current context.** A switch to `ctx_sel == active_ctx` reloads the same image and still acks.
- **Out-of-range switch.** If `ctx_sel ≥ NUM_CTX`, only `cfg_err` pulses; the switch is ignored.
- **Same-cycle switch and load.** When `write_en` is accepted and `ctx_switch` targets the same context in the same IDLE cycle, the switch applies immediately with the old contents and the commit updates `r_data_out` later.
- **FU enable.** `on_off_vector_fu` ← `on_off` on every edge. It has no effect on storage.

## Timing
- The load is accepted at edge E0. Words are written at E1..E`NUM_WORDS`, and `write_ack` is high in the cycle after E`NUM_WORDS`.
- Accept-to-ack is `NUM_WORDS+1` cycles. Minimum load period is `NUM_WORDS+2` cycles, because `write_rdy` is low in ACK.
- Immediate switch: request to `switch_ack` is 1 cycle, and `r_data_out` is valid in the same cycle as `switch_ack`.
- `on_off` to `on_off_vector_fu` latency is 1 cycle.
- All outputs are registered, except `write_rdy`, which is decoded from the state register.

## Structure
- `config_mem_pkg` holds:
  - the state enum (IDLE, WRITE, ACK);
  - a `ctx_w` function;
  - the `cfg_word_t` typedef parameterised by the package `WIDTH` default.
- Sub-module `config_mem_bank`: one context, `NUM_WORDS×WIDTH` flops with a single-word write port and a full parallel read. It is instantiated `NUM_CTX` times by a generate loop.

## Test plan
All scenarios use the defaults (WIDTH=16, NUM_WORDS=9, NUM_CTX=4).
- **Reset and full load.** Reset, then load ctx0 with word i = i*10 and mask 0x1FF → `write_ack` exactly 10 cycles after accept. `r_data_out[i] == i*10` when `write_ack` is high. `write_rdy` is 0 from accept through ACK.
- **Masked load to an inactive context, then switch.** Load ctx2 with 0xAAAA and mask 0x005 → `r_data_out` is unchanged. Then `ctx_switch` with `ctx_sel=2` → `switch_ack` 1 cycle later, words 0 and 2 = 0xAAAA, others 0, `active_ctx=2`.
- **Deferred switch.** Issue `ctx_switch` to ctx1 while ctx1 is in WRITE at index 4 → `active_ctx` holds its old value until ACK. `switch_ack` and `write_ack` are high in the same cycle, and `r_data_out` shows the new ctx1 image.
- **Out-of-range indices and ignored request.** Switch with `ctx_sel` out of range (use a build with NUM_CTX=3, ctx_sel=3) → `cfg_err` pulse and `active_ctx` unchanged. `write_en` during WRITE → ignored, with no extra ack.
- **Reset mid-load and FU enable.** Assert `reset` at index 5 → no `write_ack`, `r_data_out` all 0, `write_rdy` is 1. Toggle `on_off` 0→1→0 → `on_off_vector_fu` follows 1 cycle later.
